// File: rtl/trace_record_fifo.sv
// trace_record_fifo
// Buffers whole trace records from the commit/ILA snapshot bus and replays
// each one as BEATS consecutive BEAT_W-bit beats, least-significant beat first,
// towards the AXI read-out slave. break_full stalls the core while no record
// slot is free. Dropping en flushes every record and the accepted-record tally.

module trace_record_fifo #(
  parameter int REC_W  = 1664,
  parameter int BEAT_W = 128,
  parameter int DEPTH  = 4
) (
  input  logic                         s_axi_aclk,
  input  logic                         s_axi_areset,
  input  logic                         en,
  input  logic                         rec_valid,
  output logic                         rec_ready,
  input  logic [REC_W-1:0]             rec_data,
  output logic                         beat_valid,
  input  logic                         beat_ready,
  output logic [BEAT_W-1:0]            beat_data,
  output logic                         beat_last,
  output logic [3:0]                   beat_idx,
  output logic                         break_full,
  output logic [$clog2(DEPTH+1)-1:0]   rec_count,
  output logic [63:0]                  rec_total
);

  localparam int BEATS = REC_W / BEAT_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OFF_W = $clog2(REC_W);
  localparam logic [3:0]       LAST_BEAT = 4'(BEATS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

  // Storage and bookkeeping state
  logic [REC_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [3:0]       beat_cnt_r;
  logic [63:0]      total_r;

  // Combinational helpers
  logic             flush_s;
  logic             push_s;
  logic             pop_s;
  logic             pop_last_s;
  logic [REC_W-1:0] rd_rec_s;
  logic [OFF_W-1:0] beat_off_s;

  // Handshake decode, beat selection and status outputs
  always_comb begin
    flush_s    = s_axi_areset || !en;
    rec_ready  = !flush_s && (count_r < FULL_CNT);
    beat_valid = !flush_s && (count_r != {CNT_W{1'b0}});
    push_s     = rec_valid && rec_ready;
    pop_s      = beat_valid && beat_ready;
    pop_last_s = pop_s && (beat_cnt_r == LAST_BEAT);
    beat_last  = beat_valid && (beat_cnt_r == LAST_BEAT);
    beat_idx   = beat_cnt_r;
    break_full = !en || (count_r == FULL_CNT);
    rec_count  = count_r;
    rec_total  = total_r;
    rd_rec_s   = mem_r[rd_ptr_r];
    beat_off_s = OFF_W'(beat_cnt_r) * OFF_W'(BEAT_W);
    beat_data  = rd_rec_s[beat_off_s +: BEAT_W];
  end

  // Record slot write; contents survive flush and are only overwritten by pushes
  always_ff @(posedge s_axi_aclk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= rec_data;
    end
  end

  // Pointers, occupancy, beat position and accepted-record tally
  always_ff @(posedge s_axi_aclk) begin
    if (flush_s) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      beat_cnt_r <= 4'd0;
      total_r    <= 64'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
        total_r  <= total_r + 64'd1;
      end
      if (pop_s) begin
        if (beat_cnt_r == LAST_BEAT) begin
          beat_cnt_r <= 4'd0;
          rd_ptr_r   <= rd_ptr_r + PTR_W'(1'b1);
        end else begin
          beat_cnt_r <= beat_cnt_r + 4'd1;
        end
      end
      // A push and a completed record in the same cycle cancel out
      case ({push_s, pop_last_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_record_fifo.sv
// tb_trace_record_fifo
// Randomized and directed stimulus for trace_record_fifo, checked every cycle
// against a queue-of-records reference model.

module tb_trace_record_fifo;

  localparam int REC_W  = 1664;
  localparam int BEAT_W = 128;
  localparam int DEPTH  = 4;
  localparam int BEATS  = 13;
  localparam int VW     = 1 + 1 + 4 + 1 + 1 + 3 + 64 + BEAT_W;

  logic              clk;
  logic              areset;
  logic              en;
  logic              rec_valid;
  logic              rec_ready;
  logic [REC_W-1:0]  rec_data;
  logic              beat_valid;
  logic              beat_ready;
  logic [BEAT_W-1:0] beat_data;
  logic              beat_last;
  logic [3:0]        beat_idx;
  logic              break_full;
  logic [2:0]        rec_count;
  logic [63:0]       rec_total;

  int checks;
  int errors;

  // Reference model: queue of whole records, beat position in the head record
  logic [REC_W-1:0] mq[$];
  int               mpos;
  logic [63:0]      mtot;

  trace_record_fifo #(.REC_W(REC_W), .BEAT_W(BEAT_W), .DEPTH(DEPTH)) dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (areset),
    .en           (en),
    .rec_valid    (rec_valid),
    .rec_ready    (rec_ready),
    .rec_data     (rec_data),
    .beat_valid   (beat_valid),
    .beat_ready   (beat_ready),
    .beat_data    (beat_data),
    .beat_last    (beat_last),
    .beat_idx     (beat_idx),
    .break_full   (break_full),
    .rec_count    (rec_count),
    .rec_total    (rec_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [VW-1:0] exp_vec();
    logic ok, v;
    logic [BEAT_W-1:0] d;
    logic [REC_W-1:0] head;
    ok = en && !areset;
    v  = ok && (mq.size() != 0);
    d  = {BEAT_W{1'b0}};
    if (v) begin
      head = mq[0];
      d = head[mpos*BEAT_W +: BEAT_W];
    end
    return {v, (v && mpos == BEATS-1), 4'(mpos), (ok && mq.size() < DEPTH),
            (!en || mq.size() == DEPTH), 3'(mq.size()), mtot, d};
  endfunction

  function automatic logic [VW-1:0] obs_vec(input logic mask);
    return {beat_valid, beat_last, beat_idx, rec_ready, break_full, rec_count,
            rec_total, (mask ? beat_data : {BEAT_W{1'b0}})};
  endfunction

  function automatic logic [REC_W-1:0] rand_rec();
    logic [REC_W-1:0] r;
    for (int i = 0; i < REC_W/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Advance one clock and apply the specification's rules to the model
  task automatic tick();
    logic push, pop;
    logic [REC_W-1:0] d;
    push = en && !areset && rec_valid && (mq.size() < DEPTH);
    pop  = en && !areset && (mq.size() != 0) && beat_ready;
    d    = rec_data;
    @(posedge clk);
    if (areset || !en) begin
      mq.delete();
      mpos = 0;
      mtot = 64'd0;
    end else begin
      if (pop) begin
        if (mpos == BEATS-1) begin
          void'(mq.pop_front());
          mpos = 0;
        end else begin
          mpos++;
        end
      end
      if (push) begin
        mq.push_back(d);
        mtot = mtot + 64'd1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [VW-1:0] e;
    areset = 1'b1; en = 1'b1; rec_valid = 1'b0; beat_ready = 1'b0;
    rec_data = {REC_W{1'b0}};
    @(negedge clk);
    tick();
    #1;
    e = exp_vec();
    if (obs_vec(e[VW-1]) !== e) begin
      errors++; $display("FAIL reset_held got=%h want=%h", obs_vec(e[VW-1]), e);
    end
    checks++;
    if (rec_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got=%b want=0", rec_ready);
    end
    checks++;
    tick();
    areset = 1'b0; en = 1'b0;
    #1;
    e = exp_vec();
    if (obs_vec(e[VW-1]) !== e) begin
      errors++; $display("FAIL reset_en_low got=%h want=%h", obs_vec(e[VW-1]), e);
    end
    checks++;
    if (break_full !== 1'b1) begin
      errors++; $display("FAIL reset_break_full got=%b want=1", break_full);
    end
    checks++;
    tick();
    en = 1'b1;
    #1;
    e = exp_vec();
    if (obs_vec(e[VW-1]) !== e) begin
      errors++; $display("FAIL reset_en_high got=%h want=%h", obs_vec(e[VW-1]), e);
    end
    checks++;
    if ({rec_ready, break_full, beat_valid, beat_idx, rec_count} !== {1'b1, 1'b0, 1'b0, 4'd0, 3'd0}) begin
      errors++; $display("FAIL reset_idle got=%b%b%b %0d %0d want=100 0 0",
                         rec_ready, break_full, beat_valid, beat_idx, rec_count);
    end
    checks++;
  endtask

  task automatic test_single();
    logic [VW-1:0] e;
    logic [REC_W-1:0] r;
    logic [BEAT_W-1:0] want;
    for (int k = 0; k < BEATS; k++) r[k*BEAT_W +: BEAT_W] = {16{8'(k)}};
    rec_valid = 1'b1; rec_data = r; beat_ready = 1'b1;
    #1;
    tick();
    rec_valid = 1'b0;
    for (int c = 0; c < BEATS + 2; c++) begin
      #1;
      e = exp_vec();
      if (obs_vec(e[VW-1]) !== e) begin
        errors++; $display("FAIL single cyc=%0d got=%h want=%h", c, obs_vec(e[VW-1]), e);
      end
      checks++;
      if (c < BEATS) begin
        want = {16{8'(c)}};
        if ({beat_valid, beat_idx, beat_last, beat_data} !== {1'b1, 4'(c), (c == BEATS-1), want}) begin
          errors++; $display("FAIL single_beat k=%0d got=%b %0d %b %h want beat %h",
                             c, beat_valid, beat_idx, beat_last, beat_data, want);
        end
        checks++;
      end
      tick();
    end
    if (rec_count !== 3'd0 || rec_total !== 64'd1) begin
      errors++; $display("FAIL single_end count=%0d total=%0d want 0 1", rec_count, rec_total);
    end
    checks++;
  endtask

  task automatic test_fill();
    logic [VW-1:0] e;
    logic [REC_W-1:0] recs [5];
    logic acc;
    int i;
    for (int k = 0; k < 5; k++) recs[k] = rand_rec();
    i = 0;
    beat_ready = 1'b0;
    for (int c = 0; c < 90; c++) begin
      if (c == 10) begin
        if (rec_ready !== 1'b0 || break_full !== 1'b1 || rec_count !== 3'd4) begin
          errors++; $display("FAIL fill_full ready=%b brk=%b count=%0d want 0 1 4",
                             rec_ready, break_full, rec_count);
        end
        checks++;
        beat_ready = 1'b1;
      end
      rec_valid = (i < 5);
      rec_data  = recs[i % 5];
      #1;
      e = exp_vec();
      if (obs_vec(e[VW-1]) !== e) begin
        errors++; $display("FAIL fill cyc=%0d got=%h want=%h", c, obs_vec(e[VW-1]), e);
      end
      checks++;
      acc = rec_valid && en && (mq.size() < DEPTH);
      tick();
      if (acc) i++;
    end
    rec_valid = 1'b0;
    if (rec_count !== 3'd0 || rec_total !== 64'd6) begin
      errors++; $display("FAIL fill_end count=%0d total=%0d want 0 6", rec_count, rec_total);
    end
    checks++;
  endtask

  task automatic test_backpressure();
    logic [VW-1:0] e;
    beat_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rec_valid = 1'b1; rec_data = rand_rec();
      #1;
      tick();
    end
    rec_valid = 1'b0;
    for (int c = 0; c < 60; c++) begin
      beat_ready = c[0];
      #1;
      e = exp_vec();
      if (obs_vec(e[VW-1]) !== e) begin
        errors++; $display("FAIL backpressure cyc=%0d got=%h want=%h", c, obs_vec(e[VW-1]), e);
      end
      checks++;
      tick();
    end
    if (rec_count !== 3'd0) begin
      errors++; $display("FAIL backpressure_end count=%0d want 0", rec_count);
    end
    checks++;
  endtask

  task automatic test_simultaneous();
    logic [VW-1:0] e;
    beat_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rec_valid = 1'b1; rec_data = rand_rec();
      #1;
      tick();
    end
    rec_valid = 1'b0; beat_ready = 1'b1;
    for (int c = 0; c < 20 && mpos != BEATS-1; c++) begin
      #1;
      e = exp_vec();
      if (obs_vec(e[VW-1]) !== e) begin
        errors++; $display("FAIL simul_run cyc=%0d got=%h want=%h", c, obs_vec(e[VW-1]), e);
      end
      checks++;
      tick();
    end
    rec_valid = 1'b1; rec_data = rand_rec();
    #1;
    tick();
    rec_valid = 1'b0; beat_ready = 1'b0;
    #1;
    if (rec_count !== 3'd2) begin
      errors++; $display("FAIL simul_count2 count=%0d want 2", rec_count);
    end
    checks++;
    // Fill to DEPTH, then hold a pending record across the last-beat pop
    rec_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      rec_data = (mq.size() < DEPTH || c == 0) ? rand_rec() : rec_data;
      beat_ready = (c >= 4);
      #1;
      e = exp_vec();
      if (obs_vec(e[VW-1]) !== e) begin
        errors++; $display("FAIL simul_full cyc=%0d got=%h want=%h", c, obs_vec(e[VW-1]), e);
      end
      checks++;
      if (c >= 4 && mpos == BEATS-1 && mq.size() == DEPTH) begin
        if (rec_ready !== 1'b0 || beat_last !== 1'b1) begin
          errors++; $display("FAIL simul_no_pass ready=%b last=%b want 0 1", rec_ready, beat_last);
        end
        checks++;
        tick();
        #1;
        if (rec_ready !== 1'b1 || rec_count !== 3'd3) begin
          errors++; $display("FAIL simul_next ready=%b count=%0d want 1 3", rec_ready, rec_count);
        end
        checks++;
        tick();
        #1;
        if (rec_count !== 3'd4) begin
          errors++; $display("FAIL simul_refill count=%0d want 4", rec_count);
        end
        checks++;
        break;
      end
      tick();
    end
    rec_valid = 1'b0; beat_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      #1;
      e = exp_vec();
      if (obs_vec(e[VW-1]) !== e) begin
        errors++; $display("FAIL simul_drain cyc=%0d got=%h want=%h", c, obs_vec(e[VW-1]), e);
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_flush();
    logic [VW-1:0] e;
    rec_valid = 1'b1; rec_data = rand_rec(); beat_ready = 1'b1;
    #1;
    tick();
    rec_valid = 1'b0;
    for (int c = 0; c < 20 && mpos != 6; c++) begin
      #1;
      tick();
    end
    en = 1'b0;
    #1;
    tick();
    #1;
    e = exp_vec();
    if (obs_vec(e[VW-1]) !== e) begin
      errors++; $display("FAIL flush_model got=%h want=%h", obs_vec(e[VW-1]), e);
    end
    checks++;
    if ({beat_valid, beat_idx, rec_count, break_full} !== {1'b0, 4'd0, 3'd0, 1'b1} || rec_total !== 64'd0) begin
      errors++; $display("FAIL flush_state valid=%b idx=%0d count=%0d brk=%b total=%0d want 0 0 0 1 0",
                         beat_valid, beat_idx, rec_count, break_full, rec_total);
    end
    checks++;
    en = 1'b1; rec_valid = 1'b1; rec_data = rand_rec();
    #1;
    tick();
    rec_valid = 1'b0;
    for (int c = 0; c < BEATS + 2; c++) begin
      #1;
      e = exp_vec();
      if (obs_vec(e[VW-1]) !== e) begin
        errors++; $display("FAIL flush_restart cyc=%0d got=%h want=%h", c, obs_vec(e[VW-1]), e);
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] e;
    for (int c = 0; c < 1500; c++) begin
      areset     = ($urandom_range(0, 299) == 0);
      en         = ($urandom_range(0, 59) != 0);
      rec_valid  = $urandom_range(0, 1) == 1;
      beat_ready = ($urandom_range(0, 3) != 0);
      rec_data   = rand_rec();
      #1;
      e = exp_vec();
      if (obs_vec(e[VW-1]) !== e) begin
        errors++; $display("FAIL random cyc=%0d got=%h want=%h", c, obs_vec(e[VW-1]), e);
      end
      checks++;
      tick();
    end
    areset = 1'b0; en = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mpos   = 0;
    mtot   = 64'd0;
    test_reset();
    test_single();
    test_fill();
    test_backpressure();
    test_simultaneous();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
